// File: rtl/lcd_seq_pkg.sv
// Shared state encoding and default bus timing for the character-LCD sequencer.
package lcd_seq_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_SETUP = 3'd1;
    localparam state_t ST_PULSE = 3'd2;
    localparam state_t ST_HOLD  = 3'd3;
    localparam state_t ST_DONE  = 3'd4;

    localparam int DEF_SETUP_CYCLES  = 2;
    localparam int DEF_E_HIGH_CYCLES = 12;
    localparam int DEF_HOLD_CYCLES   = 2;
    localparam int DEF_BUSY_POLL     = 1;
    localparam int DEF_POLL_MAX      = 255;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/lcd_seq_timer.sv
// Load/decrement phase counter; stops at zero instead of wrapping.
module lcd_seq_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic         zero
);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (load) begin
            count <= value;
        end else if (count != '0) begin
            count <= count - W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/lcd_bus_sequencer.sv
// Avalon-MM slave that turns single read/write requests into HD44780-style
// bus cycles (setup, E pulse, hold), with optional busy-flag polling after writes.
module lcd_bus_sequencer
    import lcd_seq_pkg::*;
#(
    parameter int SETUP_CYCLES  = DEF_SETUP_CYCLES,
    parameter int E_HIGH_CYCLES = DEF_E_HIGH_CYCLES,
    parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
    parameter int BUSY_POLL     = DEF_BUSY_POLL,
    parameter int POLL_MAX      = DEF_POLL_MAX
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] address,
    input  logic       read,
    input  logic       write,
    input  logic [7:0] writedata,
    output logic [7:0] readdata,
    output logic       waitrequest,
    output logic       busy_timeout,
    output logic       LCD_E,
    output logic       LCD_RS,
    output logic       LCD_RW,
    inout  wire  [7:0] LCD_data
);

    localparam int TW = $clog2(max3(SETUP_CYCLES, E_HIGH_CYCLES, HOLD_CYCLES) + 1);
    localparam int PW = $clog2(POLL_MAX + 1);

    // Phase counter is loaded with N-1 so a phase lasts exactly N cycles.
    localparam logic [TW-1:0] SETUP_LD = TW'(SETUP_CYCLES - 1);
    localparam logic [TW-1:0] PULSE_LD = TW'(E_HIGH_CYCLES - 1);
    localparam logic [TW-1:0] HOLD_LD  = TW'(HOLD_CYCLES - 1);
    localparam logic [PW-1:0] POLL_LIM = PW'(POLL_MAX);

    state_t          state;
    logic            poll;
    logic            is_wr;
    logic            rs_q;
    logic            rw_q;
    logic [7:0]      data_q;
    logic            busy_bit;
    logic [PW-1:0]   poll_cnt;
    logic            tmr_load;
    logic [TW-1:0]   tmr_value;
    logic            tmr_zero;
    logic            drive;

    lcd_seq_timer #(.W(TW)) u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (tmr_load),
        .value   (tmr_value),
        .zero    (tmr_zero)
    );

    always_comb begin
        tmr_load  = 1'b0;
        tmr_value = '0;
        case (state)
            ST_IDLE: begin
                tmr_load  = read | write;
                tmr_value = SETUP_LD;
            end
            ST_SETUP: begin
                tmr_load  = tmr_zero;
                tmr_value = PULSE_LD;
            end
            ST_PULSE: begin
                tmr_load  = tmr_zero;
                tmr_value = HOLD_LD;
            end
            ST_HOLD: begin
                tmr_load  = tmr_zero;
                tmr_value = SETUP_LD;
            end
            default: begin
                tmr_load  = 1'b0;
                tmr_value = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            poll         <= 1'b0;
            is_wr        <= 1'b0;
            rs_q         <= 1'b0;
            rw_q         <= 1'b1;
            data_q       <= 8'h00;
            busy_bit     <= 1'b0;
            poll_cnt     <= '0;
            readdata     <= 8'h00;
            busy_timeout <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (read | write) begin
                        rs_q     <= address[1];
                        rw_q     <= write ? 1'b0 : address[0];
                        is_wr    <= write;
                        data_q   <= writedata;
                        poll     <= 1'b0;
                        poll_cnt <= '0;
                        if (write) begin
                            busy_timeout <= 1'b0;
                        end
                        state <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (tmr_zero) begin
                        state <= ST_PULSE;
                    end
                end
                ST_PULSE: begin
                    if (tmr_zero) begin
                        if (poll) begin
                            busy_bit <= LCD_data[7];
                            if (poll_cnt != POLL_LIM) begin
                                poll_cnt <= poll_cnt + PW'(1);
                            end
                        end else if (rw_q) begin
                            readdata <= LCD_data;
                        end
                        state <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (tmr_zero) begin
                        if (poll) begin
                            if (busy_bit && (poll_cnt < POLL_LIM)) begin
                                state <= ST_SETUP;
                            end else begin
                                busy_timeout <= busy_bit | busy_timeout;
                                rw_q         <= 1'b1;
                                state        <= ST_DONE;
                            end
                        end else if ((BUSY_POLL != 0) && is_wr) begin
                            // Busy-flag read: RS=0, RW=1, bit 7 is the flag.
                            poll  <= 1'b1;
                            rs_q  <= 1'b0;
                            rw_q  <= 1'b1;
                            state <= ST_SETUP;
                        end else begin
                            rw_q  <= 1'b1;
                            state <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    poll  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // The panel owns the bus whenever RW=1; we drive only during our own write phases.
    assign drive       = !rw_q && ((state == ST_SETUP) || (state == ST_PULSE) || (state == ST_HOLD));
    assign LCD_data    = drive ? data_q : 8'hzz;
    assign LCD_E       = (state == ST_PULSE);
    assign LCD_RS      = rs_q;
    assign LCD_RW      = rw_q;
    assign waitrequest = (read | write) & (state != ST_DONE);

endmodule

// File: tb/tb_lcd_bus_sequencer.sv
// Bench for lcd_bus_sequencer: one instance without polling, one with POLL_MAX=4,
// each with a small panel model on its data bus.
module tb_lcd_bus_sequencer;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [1:0] address [2];
    logic       read [2];
    logic       write [2];
    logic [7:0] writedata [2];
    logic [7:0] readdata [2];
    logic       waitrequest [2];
    logic       busy_timeout [2];
    logic       lcd_e [2];
    logic       lcd_rs [2];
    logic       lcd_rw [2];
    wire  [7:0] bus0;
    wire  [7:0] bus1;

    logic [7:0] model_val;
    int         busy_left;
    logic       always_busy;
    logic       busy_now;

    int compared;
    int mismatched;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    // Panel models: drive the bus whenever the sequencer asks for a read.
    assign busy_now = always_busy || (busy_left > 0);
    assign bus0 = lcd_rw[0] ? model_val : 8'hzz;
    assign bus1 = lcd_rw[1] ? {busy_now, 7'h11} : 8'hzz;

    always @(negedge lcd_e[1]) begin
        if (lcd_rw[1] && !lcd_rs[1] && busy_left > 0) busy_left <= busy_left - 1;
    end

    lcd_bus_sequencer #(.BUSY_POLL(0)) u_plain (
        .clk(clk), .reset_n(reset_n), .address(address[0]), .read(read[0]), .write(write[0]),
        .writedata(writedata[0]), .readdata(readdata[0]), .waitrequest(waitrequest[0]),
        .busy_timeout(busy_timeout[0]), .LCD_E(lcd_e[0]), .LCD_RS(lcd_rs[0]), .LCD_RW(lcd_rw[0]),
        .LCD_data(bus0)
    );

    lcd_bus_sequencer #(.BUSY_POLL(1), .POLL_MAX(4)) u_poll (
        .clk(clk), .reset_n(reset_n), .address(address[1]), .read(read[1]), .write(write[1]),
        .writedata(writedata[1]), .readdata(readdata[1]), .waitrequest(waitrequest[1]),
        .busy_timeout(busy_timeout[1]), .LCD_E(lcd_e[1]), .LCD_RS(lcd_rs[1]), .LCD_RW(lcd_rw[1]),
        .LCD_data(bus1)
    );

    function automatic logic [7:0] bus_of(input int u);
        return (u == 0) ? bus0 : bus1;
    endfunction

    function automatic logic [7:0] model_of(input int u);
        return (u == 0) ? model_val : {busy_now, 7'h11};
    endfunction

    // Driver: issue one request at cycle 0 and observe until waitrequest falls.
    task automatic run_txn(input int u, input logic rd, input logic wr, input logic [1:0] addr,
                           input logic [7:0] data, input int budget,
                           output int done_at, output int e_first, output int e_cycles,
                           output int strobes, output logic [7:0] bus_last,
                           output logic [1:0] first_rsrw, output int poll_bad,
                           output int drive_bad, output logic bt_at_1);
        logic prev_e;
        done_at = -1; e_first = -1; e_cycles = 0; strobes = 0; bus_last = 8'h00;
        first_rsrw = 2'b00; poll_bad = 0; drive_bad = 0; bt_at_1 = 1'b0; prev_e = 1'b0;
        address[u] = addr; read[u] = rd; write[u] = wr; writedata[u] = data;
        for (int k = 1; k <= budget && done_at < 0; k++) begin
            @(posedge clk); #1;
            if (k == 1) bt_at_1 = busy_timeout[u];
            if (lcd_e[u] && !prev_e) begin
                strobes++;
                if (strobes == 1) e_first = k;
            end
            if (lcd_e[u] && strobes == 1) begin
                e_cycles++;
                bus_last = bus_of(u);
                first_rsrw = {lcd_rs[u], lcd_rw[u]};
            end
            if (lcd_e[u] && strobes > 1 && (lcd_rs[u] || !lcd_rw[u])) poll_bad++;
            if (!lcd_rw[u] && bus_of(u) !== data) drive_bad++;
            if (lcd_rw[u] && bus_of(u) !== model_of(u)) drive_bad++;
            prev_e = lcd_e[u];
            if (!waitrequest[u]) done_at = k;
        end
        read[u] = 1'b0; write[u] = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        model_val = 8'h5A; busy_left = 0; always_busy = 1'b0;
        for (int u = 0; u < 2; u++) begin
            address[u] = 2'b00; read[u] = 1'b0; write[u] = 1'b0; writedata[u] = 8'h00;
        end
        repeat (3) @(posedge clk);
        #1;
        compared++; if (lcd_e[0] !== 1'b0) begin mismatched++; $display("FAIL reset_e got=%b want=0", lcd_e[0]); end
        compared++; if (lcd_rs[0] !== 1'b0) begin mismatched++; $display("FAIL reset_rs got=%b want=0", lcd_rs[0]); end
        compared++; if (lcd_rw[0] !== 1'b1) begin mismatched++; $display("FAIL reset_rw got=%b want=1", lcd_rw[0]); end
        compared++; if (readdata[0] !== 8'h00) begin mismatched++; $display("FAIL reset_readdata got=%h want=00", readdata[0]); end
        compared++; if (busy_timeout[1] !== 1'b0) begin mismatched++; $display("FAIL reset_timeout got=%b want=0", busy_timeout[1]); end
        compared++; if (bus0 !== 8'h5A) begin mismatched++; $display("FAIL reset_bus_float got=%h want=5a", bus0); end
        @(negedge clk); reset_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_write_timing();
        int done_at, e_first, e_cycles, strobes, poll_bad, drive_bad;
        logic [7:0] bus_last; logic [1:0] rsrw; logic bt1;
        model_val = 8'h5A;
        exp_q.push_back(8'h38);
        run_txn(0, 1'b0, 1'b1, 2'b00, 8'h38, 40, done_at, e_first, e_cycles, strobes, bus_last, rsrw, poll_bad, drive_bad, bt1);
        compared++; if (done_at !== 17) begin mismatched++; $display("FAIL wr_done_cycle got=%0d want=17", done_at); end
        compared++; if (e_first !== 3) begin mismatched++; $display("FAIL wr_e_rise got=%0d want=3", e_first); end
        compared++; if (e_cycles !== 12) begin mismatched++; $display("FAIL wr_e_width got=%0d want=12", e_cycles); end
        compared++; if (strobes !== 1) begin mismatched++; $display("FAIL wr_strobes got=%0d want=1", strobes); end
        compared++; if (rsrw !== 2'b00) begin mismatched++; $display("FAIL wr_rsrw got=%b want=00", rsrw); end
        compared++; if (drive_bad !== 0) begin mismatched++; $display("FAIL wr_bus_drive got=%0d bad cycles want=0", drive_bad); end
        compared++; if (bus_last !== exp_q[0]) begin mismatched++; $display("FAIL wr_data got=%h want=%h", bus_last, exp_q[0]); end
        void'(exp_q.pop_front());
    endtask

    task automatic test_read();
        int done_at, e_first, e_cycles, strobes, poll_bad, drive_bad;
        logic [7:0] bus_last; logic [1:0] rsrw; logic bt1;
        model_val = 8'hA5;
        exp_q.push_back(8'hA5);
        run_txn(0, 1'b1, 1'b0, 2'b11, 8'h00, 40, done_at, e_first, e_cycles, strobes, bus_last, rsrw, poll_bad, drive_bad, bt1);
        compared++; if (done_at !== 17) begin mismatched++; $display("FAIL rd_done_cycle got=%0d want=17", done_at); end
        compared++; if (e_cycles !== 12) begin mismatched++; $display("FAIL rd_e_width got=%0d want=12", e_cycles); end
        compared++; if (rsrw !== 2'b11) begin mismatched++; $display("FAIL rd_rsrw got=%b want=11", rsrw); end
        compared++; if (drive_bad !== 0) begin mismatched++; $display("FAIL rd_bus_contention got=%0d want=0", drive_bad); end
        compared++; if (readdata[0] !== exp_q[0]) begin mismatched++; $display("FAIL rd_readdata got=%h want=%h", readdata[0], exp_q[0]); end
        void'(exp_q.pop_front());
        model_val = 8'h5A;
    endtask

    task automatic test_read_write_together();
        int done_at, e_first, e_cycles, strobes, poll_bad, drive_bad;
        logic [7:0] bus_last; logic [1:0] rsrw; logic bt1;
        exp_q.push_back(8'hC3);
        run_txn(0, 1'b1, 1'b1, 2'b01, 8'hC3, 40, done_at, e_first, e_cycles, strobes, bus_last, rsrw, poll_bad, drive_bad, bt1);
        compared++; if (done_at !== 17) begin mismatched++; $display("FAIL rw_both_done got=%0d want=17", done_at); end
        compared++; if (rsrw !== 2'b00) begin mismatched++; $display("FAIL rw_both_rsrw got=%b want=00", rsrw); end
        compared++; if (drive_bad !== 0) begin mismatched++; $display("FAIL rw_both_drive got=%0d want=0", drive_bad); end
        compared++; if (bus_last !== exp_q[0]) begin mismatched++; $display("FAIL rw_both_data got=%h want=%h", bus_last, exp_q[0]); end
        void'(exp_q.pop_front());
        compared++; if (readdata[0] !== 8'hA5) begin mismatched++; $display("FAIL readdata_hold got=%h want=a5", readdata[0]); end
    endtask

    task automatic test_busy_poll();
        int done_at, e_first, e_cycles, strobes, poll_bad, drive_bad;
        logic [7:0] bus_last; logic [1:0] rsrw; logic bt1;
        busy_left = 2;  // busy on the first two polls, ready on the third
        exp_q.push_back(8'h01);
        run_txn(1, 1'b0, 1'b1, 2'b10, 8'h01, 200, done_at, e_first, e_cycles, strobes, bus_last, rsrw, poll_bad, drive_bad, bt1);
        compared++; if (strobes - 1 !== 3) begin mismatched++; $display("FAIL poll_count got=%0d want=3", strobes - 1); end
        compared++; if (poll_bad !== 0) begin mismatched++; $display("FAIL poll_rsrw got=%0d bad want=0", poll_bad); end
        compared++; if (done_at !== 65) begin mismatched++; $display("FAIL poll_done got=%0d want=65", done_at); end
        compared++; if (busy_timeout[1] !== 1'b0) begin mismatched++; $display("FAIL poll_timeout got=%b want=0", busy_timeout[1]); end
        compared++; if (rsrw !== 2'b10) begin mismatched++; $display("FAIL poll_wr_rsrw got=%b want=10", rsrw); end
        compared++; if (drive_bad !== 0) begin mismatched++; $display("FAIL poll_bus got=%0d want=0", drive_bad); end
        compared++; if (bus_last !== exp_q[0]) begin mismatched++; $display("FAIL poll_wr_data got=%h want=%h", bus_last, exp_q[0]); end
        void'(exp_q.pop_front());
        compared++; if (readdata[1] !== 8'h00) begin mismatched++; $display("FAIL poll_readdata got=%h want=00", readdata[1]); end
    endtask

    task automatic test_poll_timeout();
        int done_at, e_first, e_cycles, strobes, poll_bad, drive_bad;
        logic [7:0] bus_last; logic [1:0] rsrw; logic bt1;
        always_busy = 1'b1;
        exp_q.push_back(8'h0F);
        run_txn(1, 1'b0, 1'b1, 2'b00, 8'h0F, 200, done_at, e_first, e_cycles, strobes, bus_last, rsrw, poll_bad, drive_bad, bt1);
        compared++; if (strobes - 1 !== 4) begin mismatched++; $display("FAIL tmo_polls got=%0d want=4", strobes - 1); end
        compared++; if (done_at !== 81) begin mismatched++; $display("FAIL tmo_done got=%0d want=81", done_at); end
        compared++; if (busy_timeout[1] !== 1'b1) begin mismatched++; $display("FAIL tmo_flag got=%b want=1", busy_timeout[1]); end
        compared++; if (bus_last !== exp_q[0]) begin mismatched++; $display("FAIL tmo_wr_data got=%h want=%h", bus_last, exp_q[0]); end
        void'(exp_q.pop_front());
        always_busy = 1'b0;
        exp_q.push_back(8'h06);
        run_txn(1, 1'b0, 1'b1, 2'b00, 8'h06, 200, done_at, e_first, e_cycles, strobes, bus_last, rsrw, poll_bad, drive_bad, bt1);
        compared++; if (bt1 !== 1'b0) begin mismatched++; $display("FAIL tmo_clear_on_latch got=%b want=0", bt1); end
        compared++; if (strobes !== 2) begin mismatched++; $display("FAIL tmo_next_strobes got=%0d want=2", strobes); end
        compared++; if (done_at !== 33) begin mismatched++; $display("FAIL tmo_next_done got=%0d want=33", done_at); end
        compared++; if (busy_timeout[1] !== 1'b0) begin mismatched++; $display("FAIL tmo_next_flag got=%b want=0", busy_timeout[1]); end
        compared++; if (bus_last !== exp_q[0]) begin mismatched++; $display("FAIL tmo_next_data got=%h want=%h", bus_last, exp_q[0]); end
        void'(exp_q.pop_front());
    endtask

    task automatic test_reset_mid_pulse();
        int done_at, e_first, e_cycles, strobes, poll_bad, drive_bad;
        logic [7:0] bus_last; logic [1:0] rsrw; logic bt1;
        logic seen;
        model_val = 8'h5A;
        address[0] = 2'b00; writedata[0] = 8'h3C; write[0] = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(posedge clk); #1;
            seen = lcd_e[0];
        end
        compared++; if (!seen) begin mismatched++; $display("FAIL mid_e_seen got=0 want=1"); end
        @(posedge clk); #2;
        reset_n = 1'b0;
        #1;
        compared++; if (lcd_e[0] !== 1'b0) begin mismatched++; $display("FAIL mid_reset_e got=%b want=0", lcd_e[0]); end
        compared++; if (lcd_rw[0] !== 1'b1) begin mismatched++; $display("FAIL mid_reset_rw got=%b want=1", lcd_rw[0]); end
        compared++; if (bus0 !== 8'h5A) begin mismatched++; $display("FAIL mid_reset_bus got=%h want=5a", bus0); end
        compared++; if (readdata[0] !== 8'h00) begin mismatched++; $display("FAIL mid_reset_readdata got=%h want=00", readdata[0]); end
        write[0] = 1'b0;
        @(negedge clk); reset_n = 1'b1;
        @(posedge clk); #1;
        exp_q.push_back(8'h55);
        run_txn(0, 1'b0, 1'b1, 2'b00, 8'h55, 40, done_at, e_first, e_cycles, strobes, bus_last, rsrw, poll_bad, drive_bad, bt1);
        compared++; if (done_at !== 17) begin mismatched++; $display("FAIL post_reset_done got=%0d want=17", done_at); end
        compared++; if (e_cycles !== 12) begin mismatched++; $display("FAIL post_reset_width got=%0d want=12", e_cycles); end
        compared++; if (drive_bad !== 0) begin mismatched++; $display("FAIL post_reset_drive got=%0d want=0", drive_bad); end
        compared++; if (bus_last !== exp_q[0]) begin mismatched++; $display("FAIL post_reset_data got=%h want=%h", bus_last, exp_q[0]); end
        void'(exp_q.pop_front());
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired got=running want=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        compared = 0;
        mismatched = 0;
        test_reset();
        test_write_timing();
        test_read();
        test_read_write_together();
        test_busy_poll();
        test_poll_timeout();
        test_reset_mid_pulse();
        compared++;
        if (exp_q.size() !== 0) begin
            mismatched++;
            $display("FAIL scoreboard_leftover got=%0d want=0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
